// File: rtl/bounded_array_pkg.sv
// Shared types and helpers for the bounds-checked register file.
// Holds the read-outcome encoding, the range check and the saturating add.
package bounded_array_pkg;

  typedef enum logic [1:0] {ST_OK, ST_OOB, ST_UNINIT} rd_status_e;

  function automatic logic in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[31:0];
  endfunction

endpackage

// File: rtl/bounded_array_addr_chk.sv
// Combinational unsigned range check of one address against DEPTH.
module bounded_array_addr_chk
  import bounded_array_pkg::*;
#(
  parameter int          ADDR_W = 3,
  parameter int unsigned DEPTH  = 4
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              ok
);

  assign ok = in_range(32'(addr), DEPTH);

endmodule

// File: rtl/bounded_array_rf.sv
// Bounds-checked register file: 1 write port, 1 registered read port, per-entry
// valid bits, and a saturating violation counter with sticky flag.
module bounded_array_rf
  import bounded_array_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 4,
  parameter int               ADDR_W    = $clog2(DEPTH) + 1,
  parameter logic [WIDTH-1:0] OOB_VALUE = '0,
  parameter int               CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              rd_oob,
  output logic              rd_uninit,
  output logic              wr_oob,
  output logic [CNT_W-1:0]  oob_count,
  output logic              oob_sticky,
  input  logic              clr_err
);

  localparam int               IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;

  logic             rd_ok, wr_ok, rd_viol, wr_viol, wr_hit;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [1:0]       v;

  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  rd_status_e       rd_status_q, rd_status_d;
  logic             wr_oob_q, wr_oob_d;
  logic [CNT_W-1:0] oob_count_q, oob_count_d;
  logic             oob_sticky_q, oob_sticky_d;

  bounded_array_addr_chk #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_rd_chk (
    .addr(rd_addr), .ok(rd_ok)
  );
  bounded_array_addr_chk #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_wr_chk (
    .addr(wr_addr), .ok(wr_ok)
  );

  assign rd_idx  = rd_addr[IDX_W-1:0];
  assign wr_idx  = wr_addr[IDX_W-1:0];
  assign rd_viol = rd_en && !rd_ok;
  assign wr_viol = wr_en && !wr_ok;
  assign wr_hit  = wr_en && wr_ok;
  assign v       = 2'(rd_viol) + 2'(wr_viol);

  always_comb begin
    vld_d = vld_q;
    if (wr_hit) vld_d[wr_idx] = 1'b1;
  end

  // Status is only non-OK in a cycle that carries rd_valid, so the qualifiers
  // drop to 0 automatically between reads while rd_data holds.
  always_comb begin
    rd_valid_d  = rd_en;
    rd_data_d   = rd_data_q;
    rd_status_d = ST_OK;
    if (rd_en) begin
      if (!rd_ok) begin
        rd_data_d   = OOB_VALUE;
        rd_status_d = ST_OOB;
      end else if (wr_hit && (wr_idx == rd_idx)) begin
        rd_data_d   = wr_data;
      end else if (!vld_q[rd_idx]) begin
        rd_data_d   = '0;
        rd_status_d = ST_UNINIT;
      end else begin
        rd_data_d   = mem_q[rd_idx];
      end
    end
  end

  // New violations take priority over a clear issued in the same cycle.
  always_comb begin
    wr_oob_d     = wr_viol;
    oob_count_d  = oob_count_q;
    oob_sticky_d = oob_sticky_q;
    if (v != 2'd0) begin
      oob_count_d  = CNT_W'(sat_add(clr_err ? 32'd0 : 32'(oob_count_q), 32'(v), 32'(CNT_MAX)));
      oob_sticky_d = 1'b1;
    end else if (clr_err) begin
      oob_count_d  = '0;
      oob_sticky_d = 1'b0;
    end
  end

  // Storage is left unreset; vld masks stale contents.
  always_ff @(posedge clk) begin
    if (wr_hit) mem_q[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q        <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_status_q  <= ST_OK;
      wr_oob_q     <= 1'b0;
      oob_count_q  <= '0;
      oob_sticky_q <= 1'b0;
    end else begin
      vld_q        <= vld_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      rd_status_q  <= rd_status_d;
      wr_oob_q     <= wr_oob_d;
      oob_count_q  <= oob_count_d;
      oob_sticky_q <= oob_sticky_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign rd_oob     = (rd_status_q == ST_OOB);
  assign rd_uninit  = (rd_status_q == ST_UNINIT);
  assign wr_oob     = wr_oob_q;
  assign oob_count  = oob_count_q;
  assign oob_sticky = oob_sticky_q;

endmodule

// File: tb/tb_bounded_array_rf.sv
// Directed bench for bounded_array_rf: a default instance plus a CNT_W=2 instance
// sharing the same stimulus, checked with immediate assertions.
module tb_bounded_array_rf;

  localparam logic [31:0] OOBV = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [2:0]  wr_addr = '0, rd_addr = '0;
  logic [31:0] wr_data = '0;

  logic [31:0] rd_data;
  logic        rd_valid, rd_oob, rd_uninit, wr_oob, oob_sticky;
  logic [7:0]  oob_count;

  logic [31:0] s_rd_data;
  logic        s_rd_valid, s_rd_oob, s_rd_uninit, s_wr_oob, s_oob_sticky;
  logic [1:0]  s_oob_count;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bounded_array_rf #(.WIDTH(32), .DEPTH(4), .OOB_VALUE(OOBV), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_oob(rd_oob), .rd_uninit(rd_uninit), .wr_oob(wr_oob),
    .oob_count(oob_count), .oob_sticky(oob_sticky), .clr_err(clr_err)
  );

  bounded_array_rf #(.WIDTH(32), .DEPTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
    .rd_oob(s_rd_oob), .rd_uninit(s_rd_uninit), .wr_oob(s_wr_oob),
    .oob_count(s_oob_count), .oob_sticky(s_oob_sticky), .clr_err(clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic we, input logic [2:0] wa, input logic [31:0] wd,
                      input logic re, input logic [2:0] ra, input logic clr);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra; clr_err = clr;
    @(posedge clk); #1;
  endtask

  task automatic chk_read(input string tag, input logic [31:0] data, input logic oob,
                          input logic uninit);
    chk({tag, ".valid"}, 32'(rd_valid), 32'd1);
    chk({tag, ".data"}, rd_data, data);
    chk({tag, ".oob"}, 32'(rd_oob), 32'(oob));
    chk({tag, ".uninit"}, 32'(rd_uninit), 32'(uninit));
  endtask

  logic [31:0] exp_d [4];

  initial begin
    exp_d[0] = 32'd0; exp_d[1] = 32'd0; exp_d[2] = 32'd1; exp_d[3] = 32'd0;

    // Reset state
    #12;
    chk("rst.rd_data", rd_data, 32'd0);
    chk("rst.rd_valid", 32'(rd_valid), 32'd0);
    chk("rst.wr_oob", 32'(wr_oob), 32'd0);
    chk("rst.count", 32'(oob_count), 32'd0);
    chk("rst.sticky", 32'(oob_sticky), 32'd0);
    rst = 1'b0;

    // Back-to-back reads of never-written entries
    for (int a = 0; a < 4; a++) begin
      step(1'b0, 3'd0, 32'd0, 1'b1, 3'(a), 1'b0);
      chk_read($sformatf("uninit%0d", a), 32'd0, 1'b0, 1'b1);
      chk("uninit.count", 32'(oob_count), 32'd0);
    end

    // Writes 0,0,1,0 then read back
    for (int a = 0; a < 4; a++) begin
      step(1'b1, 3'(a), exp_d[a], 1'b0, 3'd0, 1'b0);
      chk("wr.rd_valid", 32'(rd_valid), 32'd0);
      chk("wr.rd_uninit", 32'(rd_uninit), 32'd0);
    end
    for (int a = 0; a < 4; a++) begin
      step(1'b0, 3'd0, 32'd0, 1'b1, 3'(a), 1'b0);
      chk_read($sformatf("rd%0d", a), exp_d[a], 1'b0, 1'b0);
    end

    // Out-of-range read
    step(1'b0, 3'd0, 32'd0, 1'b1, 3'd4, 1'b0);
    chk_read("rd4", OOBV, 1'b1, 1'b0);
    chk("rd4.count", 32'(oob_count), 32'd1);
    chk("rd4.sticky", 32'(oob_sticky), 32'd1);
    chk("rd4.sat_data", s_rd_data, 32'd0);

    // Out-of-range write is dropped (5 aliases entry 1 in the low bits)
    step(1'b1, 3'd5, 32'hDEAD, 1'b0, 3'd0, 1'b0);
    chk("wr5.wr_oob", 32'(wr_oob), 32'd1);
    chk("wr5.count", 32'(oob_count), 32'd2);
    chk("wr5.rd_valid", 32'(rd_valid), 32'd0);
    chk("wr5.rd_oob", 32'(rd_oob), 32'd0);
    chk("wr5.hold", rd_data, OOBV);
    for (int a = 0; a < 4; a++) begin
      step(1'b0, 3'd0, 32'd0, 1'b1, 3'(a), 1'b0);
      if (a == 0) chk("wr5.pulse_end", 32'(wr_oob), 32'd0);
      chk_read($sformatf("post5_rd%0d", a), exp_d[a], 1'b0, 1'b0);
    end
    chk("post5.count", 32'(oob_count), 32'd2);

    // Write-first bypass, then the stored value
    step(1'b1, 3'd2, 32'hA5, 1'b1, 3'd2, 1'b0);
    chk_read("bypass", 32'hA5, 1'b0, 1'b0);
    step(1'b0, 3'd0, 32'd0, 1'b1, 3'd2, 1'b0);
    chk_read("stored", 32'hA5, 1'b0, 1'b0);

    // Two violations in one cycle
    step(1'b1, 3'd7, 32'h1234, 1'b1, 3'd6, 1'b0);
    chk_read("dual", OOBV, 1'b1, 1'b0);
    chk("dual.wr_oob", 32'(wr_oob), 32'd1);
    chk("dual.count", 32'(oob_count), 32'd4);
    chk("dual.sat_count", 32'(s_oob_count), 32'd3);

    // Saturation on the 2-bit counter
    step(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 1'b1);
    chk("clr0.count", 32'(oob_count), 32'd0);
    chk("clr0.sat_count", 32'(s_oob_count), 32'd0);
    chk("clr0.sticky", 32'(oob_sticky), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 3'd0, 32'd0, 1'b1, 3'd4, 1'b0);
      chk($sformatf("sat%0d.count", i), 32'(s_oob_count), (i > 3) ? 32'd3 : 32'(i));
      chk($sformatf("sat%0d.wide", i), 32'(oob_count), 32'(i));
    end
    step(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 1'b1);
    chk("clr.sat_count", 32'(s_oob_count), 32'd0);
    chk("clr.sat_sticky", 32'(s_oob_sticky), 32'd0);
    chk("clr.rd_valid", 32'(rd_valid), 32'd0);
    step(1'b0, 3'd0, 32'd0, 1'b1, 3'd4, 1'b1);
    chk("clrv.sat_count", 32'(s_oob_count), 32'd1);
    chk("clrv.sat_sticky", 32'(s_oob_sticky), 32'd1);
    chk("clrv.count", 32'(oob_count), 32'd1);
    chk("clrv.sticky", 32'(oob_sticky), 32'd1);

    // Reset in the middle of a read stream
    step(1'b1, 3'd7, 32'd0, 1'b1, 3'd2, 1'b0);
    chk("pre_rst.data", rd_data, 32'hA5);
    chk("pre_rst.wr_oob", 32'(wr_oob), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst.rd_data", rd_data, 32'd0);
    chk("mid_rst.rd_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst.wr_oob", 32'(wr_oob), 32'd0);
    chk("mid_rst.count", 32'(oob_count), 32'd0);
    chk("mid_rst.sticky", 32'(oob_sticky), 32'd0);
    rd_en = 1'b0; wr_en = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst.rd_valid", 32'(rd_valid), 32'd0);
    chk("post_rst.rd_uninit", 32'(rd_uninit), 32'd0);
    step(1'b0, 3'd0, 32'd0, 1'b1, 3'd2, 1'b0);
    chk_read("post_rst.rd2", 32'd0, 1'b0, 1'b1);
    step(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 1'b0);
    chk("idle.rd_valid", 32'(rd_valid), 32'd0);
    chk("idle.rd_uninit", 32'(rd_uninit), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bounded_array_rf.md
# bounded_array_rf

Parametrised, bounds-checked fixed-array register file: one synchronous write port and one registered read port over `DEPTH` entries of `WIDTH` bits. Out-of-range accesses never produce X. Reads return a defined `OOB_VALUE`, writes are dropped, and every violation is flagged and counted. Per-entry valid bits also flag reads of never-written entries. The block replaces bare unpacked-array indexing wherever an index can exceed the declared range.

## Interface
- `WIDTH`, 32: data width in bits, ≥1.
- `DEPTH`, 4: number of entries, ≥2. It need not be a power of two.
- `ADDR_W`, `$clog2(DEPTH)+1`: address width. The extra bit makes out-of-range addresses representable.
- `OOB_VALUE`, `'0`: `WIDTH`-bit value returned on an out-of-range read.
- `CNT_W`, 8: width of the violation counter.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `wr_en` input 1: write request.
- `wr_addr` input `ADDR_W`: write index.
- `wr_data` input `WIDTH`: write data.
- `rd_en` input 1: read request.
- `rd_addr` input `ADDR_W`: read index.
- `rd_data` output `WIDTH`: registered read data.
- `rd_valid` output 1: one-cycle pulse, `rd_data` is valid.
- `rd_oob` output 1: qualifies `rd_valid`; the read was out of range.
- `rd_uninit` output 1: qualifies `rd_valid`; the entry was in range but never written.
- `wr_oob` output 1: one-cycle pulse; the previous-cycle write was dropped as out of range.
- `oob_count` output `CNT_W`: saturating count of violations.
- `oob_sticky` output 1: set on the first violation, held until cleared.
- `clr_err` input 1: synchronous clear of `oob_count` and `oob_sticky`.

## Operation
- An address `a` is in range iff `a < DEPTH`. The check is unsigned, so for example addresses 4..7 are out of range when `DEPTH`=4.
- Write with `wr_en` and an in-range address: at the clock edge, `mem[wr_addr] <= wr_data` and `vld[wr_addr] <= 1`.
- Write with `wr_en` and an out-of-range address: memory and valid bits are unchanged, and `wr_oob` pulses in the next cycle.
- Read with `rd_en`, one cycle later:
  - `rd_valid` = 1.
  - If out of range: `rd_data` = `OOB_VALUE`, `rd_oob` = 1, `rd_uninit` = 0.
  - If in range and `vld` = 0: `rd_data` = `'0`, `rd_uninit` = 1.
  - Otherwise: `rd_data` = the stored value.
- Same-cycle read and write to the same in-range address: write-first bypass. `rd_data` returns `wr_data` and `rd_uninit` = 0.
- When `rd_valid` = 0, `rd_data` holds its last value and `rd_oob`/`rd_uninit` are 0.
- Violations per cycle, `v`, range 0..2: 1 for an out-of-range read request plus 1 for an out-of-range write request.
- `oob_count <= sat(oob_count + v)`, where `sat` clamps at `2**CNT_W-1`. The counter never wraps.
- `oob_sticky <= oob_sticky | (v != 0)`.
- `clr_err` together with `v` > 0 in the same cycle: the new events win. `oob_count <= v`, `oob_sticky <= 1`.
- `clr_err` alone: `oob_count <= 0`, `oob_sticky <= 0`.

## Timing
- Asynchronous reset drives every output to 0 immediately:
  - `rd_data` = `'0`; `rd_valid`, `rd_oob`, `rd_uninit`, `wr_oob` = 0.
  - `oob_count` = 0, `oob_sticky` = 0.
  - All `vld` bits = 0.
  - Memory contents are not reset. This is irrelevant, because `vld` masks them.
- Read latency is 1 cycle from `rd_en`. Write effect: visible to a read issued in the same cycle (bypass) and in any later cycle.
- Back-to-back reads every cycle are supported; throughput is 1 per cycle.
- There is no handshake or backpressure.
- `oob_count` and `oob_sticky` update 1 cycle after the offending request.
- Reset asserted mid-operation: an in-flight read is discarded. `rd_valid` is 0 in the cycle after reset deasserts unless a new `rd_en` is sampled.
- There is no state machine. All state consists of the memory, `vld`, the read pipeline register, `wr_oob`, and the error counters.

## Structure
- Package `bounded_array_pkg` holds:
  - `typedef enum logic [1:0] {ST_OK, ST_OOB, ST_UNINIT} rd_status_e`, used internally to encode the read outcome.
  - The function `in_range(addr, depth)`.
  - The saturating-add function.
- Sub-module `bounded_array_addr_chk`: combinational `in_range` check. It is instantiated twice, once for the read address and once for the write address.
- Memory is an unpacked array `logic [WIDTH-1:0] mem [DEPTH]` plus `logic [DEPTH-1:0] vld`.

## Test plan
- Reset, then read addresses 0..3 with `DEPTH`=4 → `rd_valid` each cycle, `rd_uninit` = 1, `rd_data` = 0, `oob_count` = 0.
- Write 0→0, 1→0, 2→1, 3→0, then read 0..3 → data 0, 0, 1, 0 with `rd_uninit` = 0. Read 4 → `rd_data` = `OOB_VALUE`, `rd_oob` = 1, `oob_count` = 1, `oob_sticky` = 1.
- Write `0xDEAD` to address 5, then read 0..3 → contents unchanged, `wr_oob` pulses once, `oob_count` increments by 1.
- Same-cycle write of `0xA5` to address 2 and read of address 2 → next-cycle `rd_data` = `0xA5`. Same-cycle out-of-range read 6 and out-of-range write 7 → `oob_count` increments by 2.
- With `CNT_W`=2, issue 5 out-of-range reads → `oob_count` saturates at 3. Then `clr_err` alone → 0. Then `clr_err` with an out-of-range read in the same cycle → `oob_count` = 1, `oob_sticky` = 1.
- Assert `rst` while `rd_en` is high → all outputs 0 immediately, no `rd_valid` after release, and a subsequent read returns `rd_uninit` = 1.
